// File: rtl/prog_sequencer_pkg.sv
// Shared state encoding and opcode constants for the program sequencer and the core's control FSM.
package prog_sequencer_pkg;

    localparam int WORD_W = 16;
    localparam int OPC_W  = 4;
    localparam int OPR_W  = 12;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_STEP_HOLD = 3'd3,
        S_HALT      = 3'd4
    } seq_state_t;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OPC_SHL  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_SHR  = 4'h6;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/prog_sequencer_prog_mem.sv
// Instruction store: register array with one synchronous write port and one asynchronous read port.
module prog_mem
    import prog_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program buffer and instruction sequencer feeding the bit-serial core one word at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting program bytes, waiting for run_start
// ISSUE     | one cycle: fetch mem[pc], pulse core or stop on HALT word
// WAIT      | core executing; watchdog counting
// STEP_HOLD | single-step: waiting for btn_edge before next issue
// HALT      | program finished or faulted; run_start restarts at slot 0
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              prog_clear,
    input  logic              run_start,
    input  logic              step_mode,
    input  logic              btn_edge,
    input  logic              core_done,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPR_W-1:0]  instr,
    output logic              inst_done,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              fault
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_TC     = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    seq_state_t        state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [CNT_W-1:0]  count_nx;
    logic              byte_phase, phase_nx;
    logic [7:0]        hi_byte, hi_nx;
    logic [WD_W-1:0]   wd_cnt, wd_nx;
    logic              fault_nx;
    logic [OPC_W-1:0]  opcode_nx;
    logic [OPR_W-1:0]  instr_nx;
    logic              done_nx, busy_nx, ready_nx;
    logic              mem_we;
    logic [WORD_W-1:0] mem_word;
    logic              last_slot;

    prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count[ADDR_W-1:0]),
        .wdata ({hi_byte, load_byte}),
        .raddr (pc),
        .rdata (mem_word)
    );

    assign last_slot = ({1'b0, pc} == (count - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            count      <= '0;
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            wd_cnt     <= '0;
            fault      <= 1'b0;
            opcode     <= '0;
            instr      <= '0;
            inst_done  <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            count      <= count_nx;
            byte_phase <= phase_nx;
            hi_byte    <= hi_nx;
            wd_cnt     <= wd_nx;
            fault      <= fault_nx;
            opcode     <= opcode_nx;
            instr      <= instr_nx;
            inst_done  <= done_nx;
            busy       <= busy_nx;
            load_ready <= ready_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        count_nx  = count;
        phase_nx  = byte_phase;
        hi_nx     = hi_byte;
        wd_nx     = wd_cnt;
        fault_nx  = fault;
        opcode_nx = opcode;
        instr_nx  = instr;
        done_nx   = 1'b0;
        mem_we    = 1'b0;

        if (prog_clear) begin
            // Abandons any in-flight core op silently; the core is never told.
            state_nx  = S_IDLE;
            pc_nx     = '0;
            count_nx  = '0;
            phase_nx  = 1'b0;
            wd_nx     = '0;
            fault_nx  = 1'b0;
            opcode_nx = '0;
            instr_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_start) begin
                        phase_nx = 1'b0;
                        if (count != '0) begin
                            pc_nx    = '0;
                            state_nx = S_ISSUE;
                        end
                    end else if (load_valid && load_ready) begin
                        if (!byte_phase) begin
                            hi_nx    = load_byte;
                            phase_nx = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            count_nx = count + CNT_W'(1);
                            phase_nx = 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_word[15:12] == OPC_HALT) begin
                        state_nx = S_HALT;
                    end else begin
                        opcode_nx = mem_word[15:12];
                        instr_nx  = mem_word[11:0];
                        done_nx   = 1'b1;
                        wd_nx     = '0;
                        state_nx  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        if (last_slot) begin
                            state_nx = S_HALT;
                        end else begin
                            pc_nx    = pc + ADDR_W'(1);
                            state_nx = step_mode ? S_STEP_HOLD : S_ISSUE;
                        end
                    end else if (wd_cnt == WD_TC) begin
                        fault_nx = 1'b1;
                        state_nx = S_HALT;
                    end else begin
                        wd_nx = wd_cnt + WD_W'(1);
                    end
                end
                S_STEP_HOLD: begin
                    if (btn_edge || !step_mode) begin
                        state_nx = S_ISSUE;
                    end
                end
                S_HALT: begin
                    if (run_start) begin
                        pc_nx    = '0;
                        fault_nx = 1'b0;
                        state_nx = S_ISSUE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        busy_nx  = (state_nx == S_ISSUE) || (state_nx == S_WAIT) || (state_nx == S_STEP_HOLD);
        ready_nx = (state_nx == S_IDLE) && (count_nx < CNT_DEPTH);
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: behavioural program/run model checked every cycle, plus directed literal checks.
module tb_prog_sequencer;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 64;

    localparam int PH_LOAD  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_HOLD  = 3;
    localparam int PH_STOP  = 4;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte  = 8'h00;
    logic        prog_clear = 1'b0;
    logic        run_start  = 1'b0;
    logic        step_mode  = 1'b0;
    logic        btn_edge   = 1'b0;
    logic        core_done  = 1'b0;
    logic        load_ready;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic [2:0]  pc;
    logic [3:0]  count;
    logic        busy;
    logic        fault;

    prog_sequencer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .prog_clear (prog_clear),
        .run_start  (run_start),
        .step_mode  (step_mode),
        .btn_edge   (btn_edge),
        .core_done  (core_done),
        .opcode     (opcode),
        .instr      (instr),
        .inst_done  (inst_done),
        .pc         (pc),
        .count      (count),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc++;

    // Reference model: the stored program is a queue, progress is tracked as a phase plus
    // the number of cycles the current instruction has been outstanding.
    logic [15:0] m_prog[$];
    int          m_hi;
    int          ph;
    int          age;
    int          e_pc;
    logic [3:0]  e_op;
    logic [11:0] e_instr;
    logic        e_done;
    logic        e_fault;
    logic [15:0] m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prog.delete();
            m_hi = -1; ph = PH_LOAD; age = 0; e_pc = 0;
            e_op = 4'h0; e_instr = 12'h000; e_done = 1'b0; e_fault = 1'b0;
        end else begin
            e_done = 1'b0;
            if (prog_clear) begin
                m_prog.delete();
                m_hi = -1; ph = PH_LOAD; e_pc = 0;
                e_op = 4'h0; e_instr = 12'h000; e_fault = 1'b0;
            end else begin
                case (ph)
                    PH_LOAD: begin
                        if (run_start) begin
                            m_hi = -1;
                            if (m_prog.size() != 0) begin
                                e_pc = 0;
                                ph   = PH_FETCH;
                            end
                        end else if (load_valid && m_prog.size() < DEPTH) begin
                            if (m_hi < 0) begin
                                m_hi = int'(load_byte);
                            end else begin
                                m_prog.push_back({m_hi[7:0], load_byte});
                                m_hi = -1;
                            end
                        end
                    end
                    PH_FETCH: begin
                        m_w = m_prog[e_pc];
                        if (m_w[15:12] == 4'hF) begin
                            ph = PH_STOP;
                        end else begin
                            e_op = m_w[15:12]; e_instr = m_w[11:0];
                            e_done = 1'b1; age = 0; ph = PH_EXEC;
                        end
                    end
                    PH_EXEC: begin
                        age++;
                        if (core_done) begin
                            if (e_pc == m_prog.size() - 1) begin
                                ph = PH_STOP;
                            end else begin
                                e_pc++;
                                ph = step_mode ? PH_HOLD : PH_FETCH;
                            end
                        end else if (age == TIMEOUT) begin
                            e_fault = 1'b1;
                            ph = PH_STOP;
                        end
                    end
                    PH_HOLD: begin
                        if (btn_edge || !step_mode) ph = PH_FETCH;
                    end
                    default: begin
                        if (run_start) begin
                            e_pc = 0; e_fault = 1'b0; ph = PH_FETCH;
                        end
                    end
                endcase
            end
        end
    end

    logic [26:0] exp_v, act_v;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {e_op, e_instr, e_done, e_pc[2:0], 4'(m_prog.size()),
                     (ph == PH_FETCH || ph == PH_EXEC || ph == PH_HOLD),
                     e_fault, (ph == PH_LOAD && m_prog.size() < DEPTH)};
            act_v = {opcode, instr, inst_done, pc, count, busy, fault, load_ready};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got=%h expected=%h (op,instr,done,pc,count,busy,fault,ready)",
                         cyc, act_v, exp_v);
            end
        end
    end

    // Issue log and core responder
    logic [15:0] log_w[$];
    int          log_c[$];
    int          resp_delay = 10;
    int          resp_cnt   = 0;
    logic        resp_en    = 1'b1;
    logic        noise_en   = 1'b0;

    always @(negedge clk) begin
        if (rst_n && inst_done === 1'b1) begin
            log_w.push_back({opcode, instr});
            log_c.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        core_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) core_done = 1'b1;
        end
        if (noise_en && $urandom_range(0, 15) == 0) core_done = 1'b1;
        if (inst_done === 1'b1 && resp_en) resp_cnt = resp_delay;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_b(w[15:8]);
        load_b(w[7:0]);
    endtask

    task automatic pulse_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    task automatic pulse_clear();
        prog_clear = 1'b1;
        tick();
        prog_clear = 1'b0;
    endtask

    task automatic pulse_btn();
        btn_edge = 1'b1;
        tick();
        btn_edge = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_w.size() < n && k < 300) begin
            tick();
            k++;
        end
        check("issue_arrived", int'(log_w.size() >= n), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 1000) begin
            tick();
            k++;
        end
        check("busy_dropped", int'(busy), 0);
    endtask

    task automatic clear_log();
        log_w.delete();
        log_c.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] words [9];
    int c0, a0, k0;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_inst_done", int'(inst_done), 0);
        check("rst_busy", int'(busy), 0);

        // Two-word program, free-run
        load_b(8'h1A); load_b(8'h05); load_b(8'h9C); load_b(8'h30);
        check("load2_count", int'(count), 2);
        resp_delay = 10;
        clear_log();
        c0 = cyc;
        pulse_run();
        wait_log(1);
        check("run_latency", log_c[0] - c0, 2);
        wait_idle();
        check("fr_issues", log_w.size(), 2);
        check("fr_word0", int'(log_w[0]), 16'h1A05);
        if (log_w.size() > 1) begin
            check("fr_word1", int'(log_w[1]), 16'h9C30);
            check("fr_gap", log_c[1] - log_c[0], 12);
        end
        check("fr_pc", int'(pc), 1);
        check("fr_count", int'(count), 2);

        // Overfill: 9 words into 8 slots
        pulse_clear();
        for (int i = 0; i < 9; i++) words[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        for (int i = 0; i < 8; i++) load_word(words[i]);
        check("full_ready", int'(load_ready), 0);
        check("full_count", int'(count), 8);
        load_word(words[8]);
        check("full_count_after", int'(count), 8);
        resp_delay = 2;
        clear_log();
        pulse_run();
        wait_idle();
        check("full_issues", log_w.size(), 8);
        for (int i = 0; i < 8 && i < log_w.size(); i++) check("full_word", int'(log_w[i]), int'(words[i]));
        check("full_pc", int'(pc), 7);

        // Single-step
        pulse_clear();
        load_word(16'h1111); load_word(16'h2222); load_word(16'h3333);
        step_mode = 1'b1;
        resp_delay = 3;
        clear_log();
        pulse_run();
        wait_log(1);
        repeat (20) tick();
        check("step_held", log_w.size(), 1);
        check("step_busy", int'(busy), 1);
        resp_delay = 10;
        c0 = cyc;
        pulse_btn();
        wait_log(2);
        if (log_c.size() > 1) check("step_latency", log_c[1] - c0, 2);
        pulse_btn();
        repeat (20) tick();
        check("step_btn_in_wait", log_w.size(), 2);
        pulse_btn();
        wait_idle();
        check("step_issues", log_w.size(), 3);
        check("step_pc", int'(pc), 2);
        step_mode = 1'b0;

        // Embedded HALT word
        pulse_clear();
        load_word(16'h1234); load_word(16'hF000); load_word(16'h5678);
        resp_delay = 4;
        clear_log();
        pulse_run();
        wait_idle();
        check("halt_issues", log_w.size(), 1);
        check("halt_pc", int'(pc), 1);

        // Watchdog
        pulse_clear();
        load_word(16'h2ABC);
        resp_en = 1'b0;
        clear_log();
        pulse_run();
        wait_log(1);
        a0 = cyc;
        k0 = 0;
        while (fault !== 1'b1 && k0 < 200) begin
            tick();
            k0++;
        end
        check("wd_fault_cycle", cyc - a0, TIMEOUT);
        check("wd_busy", int'(busy), 0);
        resp_en = 1'b1;
        resp_delay = 5;
        clear_log();
        c0 = cyc;
        pulse_run();
        check("wd_fault_cleared", int'(fault), 0);
        wait_log(1);
        check("wd_reissue_lat", log_c[0] - c0, 2);
        check("wd_reissue_word", int'(log_w[0]), 16'h2ABC);
        wait_idle();

        // Async reset mid-WAIT
        resp_en = 1'b0;
        clear_log();
        pulse_run();
        wait_log(1);
        rst_n = 1'b0;
        #1;
        check("arst_inst_done", int'(inst_done), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_count", int'(count), 0);
        check("arst_ready", int'(load_ready), 1);
        check("arst_opcode", int'(opcode), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // prog_clear mid-WAIT
        load_word(16'h4321);
        clear_log();
        pulse_run();
        wait_log(1);
        repeat (3) tick();
        pulse_clear();
        check("clr_count", int'(count), 0);
        check("clr_ready", int'(load_ready), 1);
        check("clr_busy", int'(busy), 0);
        check("clr_instr", int'(instr), 0);

        // Half word discarded by run_start
        load_b(8'h7E);
        pulse_run();
        tick();
        check("half_busy", int'(busy), 0);
        check("half_count", int'(count), 0);
        resp_en = 1'b1;
        load_word(16'h3D11);
        check("half_count2", int'(count), 1);
        clear_log();
        pulse_run();
        wait_log(1);
        check("half_word", int'(log_w[0]), 16'h3D11);
        wait_idle();

        // Randomised traffic against the model
        pulse_clear();
        noise_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            load_valid = ($urandom_range(0, 1) == 1);
            load_byte  = 8'($urandom);
            run_start  = ($urandom_range(0, 39) == 0);
            prog_clear = ($urandom_range(0, 299) == 0);
            btn_edge   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) step_mode = ~step_mode;
            resp_delay = $urandom_range(1, 80);
            tick();
        end
        load_valid = 1'b0; run_start = 1'b0; prog_clear = 1'b0;
        btn_edge = 1'b0; step_mode = 1'b0; noise_en = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Program buffer and instruction sequencer for the bit-serial cpu_core. Accepts a short program as byte pairs from the pin interface, stores up to DEPTH 16-bit words, and issues them one at a time to the core. Drives the core's opcode/instr and start pulse, and advances on the core's completion pulse (out_en). Supports free-run and single-step, with a per-instruction watchdog.

Parameters:
DEPTH, 8, number of instruction slots (power of two)
ADDR_W, 3, log2(DEPTH)
TIMEOUT, 64, max cycles in WAIT before a fault

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
load_valid  in  1  load_byte valid this cycle
load_byte  in  8  program byte; first byte {opcode,instr[11:8]}, second byte instr[7:0]
load_ready  out  1  high in IDLE when count<DEPTH
prog_clear  in  1  sync clear of program and sequencer state
run_start  in  1  start/restart execution from slot 0 (level sampled, act once per cycle)
step_mode  in  1  1 = wait for btn_edge before each issue after the first
btn_edge  in  1  single-cycle step advance pulse
core_done  in  1  core completion pulse (core out_en)
opcode  out  4  opcode to core, held from ISSUE until next ISSUE
instr  out  12  operand field to core, held likewise
inst_done  out  1  one-cycle issue pulse to core
pc  out  ADDR_W  slot of current/last issued instruction
count  out  ADDR_W+1  stored instruction count, 0..DEPTH
busy  out  1  state in {ISSUE,WAIT,STEP_HOLD}
fault  out  1  sticky watchdog fault

Behaviour:
- Reset (async, rst_n=0): state=IDLE; opcode,instr,pc,count,byte_phase,wd_cnt=0; inst_done=0, fault=0, load_ready=1. Memory contents need not reset.
- States: IDLE, ISSUE, WAIT, STEP_HOLD, HALT. All outputs registered.
- Priority each cycle: prog_clear > run_start > load_valid.
- prog_clear (any state): next state IDLE; count, pc, byte_phase, fault=0; a pending core op is abandoned (core not notified).
- IDLE loading: load_valid && load_ready: phase 0 latches hi byte, phase->1; phase 1 writes {hi,load_byte} to mem[count], count+1, phase->0. count==DEPTH: load_ready=0, bytes dropped, phase unchanged.
- IDLE + run_start: count==0 -> stay IDLE; else pc=0, byte_phase=0 (half word discarded), -> ISSUE. Same-cycle load_valid byte dropped.
- ISSUE (1 cycle): word=mem[pc]. opcode==4'hF (HALT word): no pulse, -> HALT. Else opcode/instr <= word, inst_done=1 next cycle, wd_cnt=0, -> WAIT.
- WAIT: wd_cnt increments per cycle. core_done: if pc==count-1 -> HALT (pc unchanged); else pc+1, -> STEP_HOLD if step_mode else ISSUE. wd_cnt reaches TIMEOUT-1 with no core_done -> fault=1, -> HALT. core_done on the same cycle as timeout wins (no fault).
- core_done outside WAIT: ignored.
- STEP_HOLD: btn_edge -> ISSUE. step_mode dropped -> ISSUE next cycle.
- HALT: busy=0. run_start -> pc=0, fault=0, -> ISSUE. load_valid ignored; reload requires prog_clear.
- run_start in ISSUE/WAIT/STEP_HOLD: ignored.
- Latency: run_start at cycle N -> inst_done high at N+2 with opcode/instr valid same cycle. core_done at M -> next inst_done at M+2 (free-run).
- pc wraps never: the last slot always terminates in HALT.
- Reset asserted mid-operation: immediate async return to reset values; inst_done deasserts without waiting for the clock.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT, STEP_HOLD, HALT) and OPC_HALT=4'hF, alongside existing opcode constants used by fsm_control.
- One sub-module: prog_mem (DEPTH x 16 register array, 1 write port, 1 async read port, no reset). Sequencer FSM, byte assembler and watchdog stay in prog_sequencer.

Test Plan:
- Load bytes 0x1A,0x05,0x9C,0x30 then run_start, free-run, core_done 10 cycles after each inst_done -> inst_done twice; opcode/instr = 1/0xA05 then 9/0xC30; HALT, pc=1, count=2, busy=0.
- Load 9 words with DEPTH=8 -> load_ready=0 after 8th word, count=8, 9th word's bytes dropped; run executes 8 words then HALT.
- step_mode=1, 3 words -> after first core_done, no inst_done until btn_edge; each btn_edge yields inst_done 2 cycles later; btn_edge in WAIT ignored.
- Word 2 of 3 = 0xF000 -> only word 1 issued, HALT reached with pc=1, no inst_done for slots 1-2.
- No core_done after issue -> fault=1 exactly TIMEOUT cycles after WAIT entry, state HALT; run_start clears fault and reissues slot 0.
- Drop rst_n mid-WAIT, and separately pulse prog_clear mid-WAIT -> outputs return to reset values (async / next edge); count=0, load_ready=1; one load byte then run_start -> half word discarded, stays IDLE.
